// File: rtl/math_round_controller.sv
// Round sequencer for the monkey arithmetic game: builds an equation from collision
// hits, checks it against the level target and manages lives, levels and pauses.
`timescale 1ns/1ps
module math_round_controller #(
    parameter int NUMBERS      = 3,
    parameter int VALUE_W      = 8,
    parameter int LIVES        = 3,
    parameter int LEVELS       = 4,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic                        startGame,
    input  logic [NUMBERS-1:0]          numberHit,
    input  logic [NUMBERS*VALUE_W-1:0]  numberValues,
    input  logic [1:0]                  operandHit,
    input  logic                        waterCollision,
    input  logic [VALUE_W-1:0]          targetValue,
    output logic [3:0]                  state,
    output logic [VALUE_W-1:0]          accumulator,
    output logic                        pendingOp,
    output logic [2:0]                  livesLeft,
    output logic [$clog2(LEVELS)-1:0]   level,
    output logic                        freezeMonkey,
    output logic                        respawnN,
    output logic                        levelUpPulse,
    output logic                        lifeLostPulse,
    output logic                        gameOver,
    output logic                        win
);
    localparam int LEVEL_W = $clog2(LEVELS);
    localparam int PAUSE_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_FRAMES - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FIRST      = 4'd1,
        OPER       = 4'd2,
        SECOND     = 4'd3,
        CHECK      = 4'd4,
        DYING      = 4'd5,
        LEVEL_DONE = 4'd6,
        GAME_OVER  = 4'd7,
        WIN        = 4'd8
    } state_t;

    state_t               cur_state;
    state_t               next_state;
    logic [VALUE_W-1:0]   next_acc;
    logic [VALUE_W-1:0]   hit_value;
    logic                 hit_any;
    logic                 next_op;
    logic [2:0]           next_lives;
    logic [LEVEL_W-1:0]   next_level;
    logic [PAUSE_W-1:0]   pause_count;
    logic [PAUSE_W-1:0]   next_count;
    logic                 level_up;
    logic                 life_lost;
    logic                 playing;

    assign state   = cur_state;
    assign hit_any = |numberHit;
    assign playing = (cur_state == FIRST) || (cur_state == OPER) ||
                     (cur_state == SECOND) || (cur_state == CHECK);

    // Scanning from the top down lets the lowest-indexed simultaneous hit win.
    always_comb begin
        hit_value = '0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (numberHit[i]) begin
                hit_value = numberValues[i*VALUE_W +: VALUE_W];
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        next_acc   = accumulator;
        next_op    = pendingOp;
        next_lives = livesLeft;
        next_level = level;
        next_count = pause_count;
        level_up   = 1'b0;
        life_lost  = 1'b0;

        if (playing && waterCollision) begin
            life_lost  = 1'b1;
            next_count = PAUSE_LOAD;
            if (livesLeft <= 3'd1) begin
                next_lives = 3'd0;
                next_state = GAME_OVER;
            end else begin
                next_lives = livesLeft - 3'd1;
                next_state = DYING;
            end
        end else begin
            case (cur_state)
                IDLE: begin
                    next_lives = LIVES_INIT;
                    next_level = '0;
                    next_acc   = '0;
                    if (startGame) next_state = FIRST;
                end
                FIRST: begin
                    if (hit_any) begin
                        next_acc   = hit_value;
                        next_state = OPER;
                    end
                end
                OPER: begin
                    if (operandHit != 2'b00) begin
                        next_op    = ~operandHit[0];
                        next_state = SECOND;
                    end
                end
                SECOND: begin
                    if (hit_any) begin
                        next_acc   = pendingOp ? (accumulator - hit_value)
                                               : (accumulator + hit_value);
                        next_state = CHECK;
                    end
                end
                CHECK: begin
                    if (accumulator == targetValue) begin
                        level_up   = 1'b1;
                        next_count = PAUSE_LOAD;
                        next_state = LEVEL_DONE;
                    end else begin
                        next_state = OPER;
                    end
                end
                DYING: begin
                    if (startOfFrame) begin
                        if (pause_count == '0) begin
                            next_acc   = '0;
                            next_state = FIRST;
                        end else begin
                            next_count = pause_count - 1'b1;
                        end
                    end
                end
                LEVEL_DONE: begin
                    if (startOfFrame) begin
                        if (pause_count != '0) begin
                            next_count = pause_count - 1'b1;
                        end else if (level == LAST_LEVEL) begin
                            next_state = WIN;
                        end else begin
                            next_level = level + 1'b1;
                            next_acc   = '0;
                            next_state = FIRST;
                        end
                    end
                end
                GAME_OVER, WIN: begin
                    if (startGame) begin
                        next_lives = LIVES_INIT;
                        next_level = '0;
                        next_acc   = '0;
                        next_state = FIRST;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Every output is registered from the next-state values so they change together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cur_state     <= IDLE;
            accumulator   <= '0;
            pendingOp     <= 1'b0;
            livesLeft     <= LIVES_INIT;
            level         <= '0;
            pause_count   <= '0;
            freezeMonkey  <= 1'b1;
            respawnN      <= 1'b1;
            levelUpPulse  <= 1'b0;
            lifeLostPulse <= 1'b0;
            gameOver      <= 1'b0;
            win           <= 1'b0;
        end else begin
            cur_state     <= next_state;
            accumulator   <= next_acc;
            pendingOp     <= next_op;
            livesLeft     <= next_lives;
            level         <= next_level;
            pause_count   <= next_count;
            freezeMonkey  <= (next_state == IDLE) || (next_state == DYING) ||
                             (next_state == LEVEL_DONE) || (next_state == GAME_OVER) ||
                             (next_state == WIN);
            respawnN      <= (next_state != DYING);
            levelUpPulse  <= level_up;
            lifeLostPulse <= life_lost;
            gameOver      <= (next_state == GAME_OVER);
            win           <= (next_state == WIN);
        end
    end

endmodule

// File: tb/tb_math_round_controller.sv
// Self-checking bench for math_round_controller: directed test-plan sequences with
// literal checks, then randomized play compared every cycle against a game model.
`timescale 1ns/1ps
module tb_math_round_controller;
    localparam int NUMBERS      = 3;
    localparam int VALUE_W      = 8;
    localparam int LIVES        = 3;
    localparam int LEVELS       = 4;
    localparam int PAUSE_FRAMES = 60;
    localparam int MOD          = 1 << VALUE_W;

    logic                       clk            = 1'b0;
    logic                       resetN         = 1'b0;
    logic                       startOfFrame   = 1'b0;
    logic                       startGame      = 1'b0;
    logic [NUMBERS-1:0]         numberHit      = '0;
    logic [NUMBERS*VALUE_W-1:0] numberValues   = '0;
    logic [1:0]                 operandHit     = 2'b00;
    logic                       waterCollision = 1'b0;
    logic [VALUE_W-1:0]         targetValue    = '0;
    logic [3:0]                 state;
    logic [VALUE_W-1:0]         accumulator;
    logic                       pendingOp;
    logic [2:0]                 livesLeft;
    logic [1:0]                 level;
    logic                       freezeMonkey;
    logic                       respawnN;
    logic                       levelUpPulse;
    logic                       lifeLostPulse;
    logic                       gameOver;
    logic                       win;

    int vectors     = 0;
    int miscompares = 0;

    int m_state   = 0;
    int m_acc     = 0;
    int m_op      = 0;
    int m_lives   = LIVES;
    int m_level   = 0;
    int m_frames  = 0;
    int m_levelup = 0;
    int m_lostup  = 0;

    always #5 clk = ~clk;

    math_round_controller #(
        .NUMBERS(NUMBERS), .VALUE_W(VALUE_W), .LIVES(LIVES),
        .LEVELS(LEVELS), .PAUSE_FRAMES(PAUSE_FRAMES)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .numberHit(numberHit), .numberValues(numberValues), .operandHit(operandHit),
        .waterCollision(waterCollision), .targetValue(targetValue), .state(state),
        .accumulator(accumulator), .pendingOp(pendingOp), .livesLeft(livesLeft),
        .level(level), .freezeMonkey(freezeMonkey), .respawnN(respawnN),
        .levelUpPulse(levelUpPulse), .lifeLostPulse(lifeLostPulse),
        .gameOver(gameOver), .win(win)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        vectors++;
        if (actual !== 32'(expected)) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Game rules as one step per clock edge, using plain integers and a frame tally.
    task automatic modelStep();
        int idx;
        int value;
        m_levelup = 0;
        m_lostup  = 0;
        if (!resetN) begin
            m_state = 0; m_acc = 0; m_op = 0; m_lives = LIVES; m_level = 0; m_frames = 0;
            return;
        end
        idx = -1;
        for (int i = NUMBERS - 1; i >= 0; i--) if (numberHit[i]) idx = i;
        value = (idx >= 0) ? int'(numberValues[idx*VALUE_W +: VALUE_W]) : 0;
        if (m_state inside {1, 2, 3, 4} && waterCollision) begin
            m_lives  = m_lives - 1;
            m_lostup = 1;
            m_frames = 0;
            m_state  = (m_lives == 0) ? 7 : 5;
        end else if (m_state == 0) begin
            if (startGame) m_state = 1;
        end else if (m_state == 1) begin
            if (idx >= 0) begin m_acc = value; m_state = 2; end
        end else if (m_state == 2) begin
            if (operandHit != 2'b00) begin m_op = operandHit[0] ? 0 : 1; m_state = 3; end
        end else if (m_state == 3) begin
            if (idx >= 0) begin
                m_acc   = m_op ? (m_acc - value + MOD) % MOD : (m_acc + value) % MOD;
                m_state = 4;
            end
        end else if (m_state == 4) begin
            if (m_acc == int'(targetValue)) begin
                m_state = 6; m_levelup = 1; m_frames = 0;
            end else begin
                m_state = 2;
            end
        end else if (m_state == 5 || m_state == 6) begin
            if (startOfFrame) m_frames++;
            if (m_frames == PAUSE_FRAMES) begin
                if (m_state == 6 && m_level == LEVELS - 1) begin
                    m_state = 8;
                end else begin
                    if (m_state == 6) m_level++;
                    m_acc   = 0;
                    m_state = 1;
                end
            end
        end else if (startGame) begin
            m_lives = LIVES; m_level = 0; m_acc = 0; m_state = 1;
        end
    endtask

    always begin
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("state", 32'(state), m_state);
        checkOutput("accumulator", 32'(accumulator), m_acc);
        checkOutput("pendingOp", 32'(pendingOp), m_op);
        checkOutput("livesLeft", 32'(livesLeft), m_lives);
        checkOutput("level", 32'(level), m_level);
        checkOutput("freezeMonkey", 32'(freezeMonkey), int'(m_state inside {0, 5, 6, 7, 8}));
        checkOutput("respawnN", 32'(respawnN), int'(m_state != 5));
        checkOutput("levelUpPulse", 32'(levelUpPulse), m_levelup);
        checkOutput("lifeLostPulse", 32'(lifeLostPulse), m_lostup);
        checkOutput("gameOver", 32'(gameOver), int'(m_state == 7));
        checkOutput("win", 32'(win), int'(m_state == 8));
    end

    task automatic applyStimulus(input logic sof, input logic start, input logic [NUMBERS-1:0] nh,
                                 input logic [1:0] op, input logic water);
        @(negedge clk);
        startOfFrame   = sof;
        startGame      = start;
        numberHit      = nh;
        operandHit     = op;
        waterCollision = water;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 2'b00, 1'b0);
    endtask

    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 2'b00, 1'b0);
            idleCycle();
        end
    endtask

    task automatic clearLevel();
        numberValues = {8'd5, 8'd4, 8'd3};
        targetValue  = 8'd7;
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b010, 2'b00, 1'b0);
        idleCycle();
        runFrames(PAUSE_FRAMES);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset state", 32'(state), 0);
        checkOutput("reset lives", 32'(livesLeft), 3);
        checkOutput("reset freeze", 32'(freezeMonkey), 1);
        checkOutput("reset respawnN", 32'(respawnN), 1);
        resetN = 1'b1;

        // Start and single step: 3 + 4 against target 7.
        numberValues = {8'd5, 8'd4, 8'd3};
        targetValue  = 8'd7;
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 1'b0);
        checkOutput("start state", 32'(state), 1);
        checkOutput("start freeze", 32'(freezeMonkey), 0);
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        checkOutput("first acc", 32'(accumulator), 3);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        checkOutput("plus state", 32'(state), 3);
        applyStimulus(1'b0, 1'b0, 3'b010, 2'b00, 1'b0);
        checkOutput("check state", 32'(state), 4);
        checkOutput("check acc", 32'(accumulator), 7);
        idleCycle();
        checkOutput("level done state", 32'(state), 6);
        checkOutput("levelUp pulse", 32'(levelUpPulse), 1);
        idleCycle();
        checkOutput("levelUp drop", 32'(levelUpPulse), 0);
        runFrames(PAUSE_FRAMES - 1);
        checkOutput("pause held", 32'(state), 6);
        runFrames(1);
        checkOutput("after pause state", 32'(state), 1);
        checkOutput("after pause level", 32'(level), 1);
        checkOutput("after pause acc", 32'(accumulator), 0);

        // Chain and wrap: 5 - 9 = 252, then + 4 = 0 against target 0.
        numberValues = {8'd4, 8'd9, 8'd5};
        targetValue  = 8'd0;
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b10, 1'b0);
        checkOutput("minus op", 32'(pendingOp), 1);
        applyStimulus(1'b0, 1'b0, 3'b010, 2'b00, 1'b0);
        checkOutput("wrap acc", 32'(accumulator), 252);
        idleCycle();
        checkOutput("chain state", 32'(state), 2);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b100, 2'b00, 1'b0);
        checkOutput("wrap zero acc", 32'(accumulator), 0);
        idleCycle();
        checkOutput("chain done", 32'(state), 6);
        runFrames(PAUSE_FRAMES);
        checkOutput("chain level", 32'(level), 2);

        // Water has priority over a number hit in SECOND.
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b01, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b1);
        checkOutput("water state", 32'(state), 5);
        checkOutput("water lives", 32'(livesLeft), 2);
        checkOutput("water acc", 32'(accumulator), 5);
        checkOutput("water respawnN", 32'(respawnN), 0);
        checkOutput("water pulse", 32'(lifeLostPulse), 1);
        runFrames(PAUSE_FRAMES);
        checkOutput("respawn state", 32'(state), 1);
        checkOutput("respawn acc", 32'(accumulator), 0);

        // Ignored and simultaneous hits.
        applyStimulus(1'b0, 1'b0, 3'b110, 2'b00, 1'b0);
        checkOutput("lowest index acc", 32'(accumulator), 9);
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        checkOutput("ignored hit state", 32'(state), 2);
        checkOutput("ignored hit acc", 32'(accumulator), 9);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b11, 1'b0);
        checkOutput("both ops", 32'(pendingOp), 0);

        // Last life.
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        runFrames(PAUSE_FRAMES);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        checkOutput("game over state", 32'(state), 7);
        checkOutput("game over lives", 32'(livesLeft), 0);
        checkOutput("game over flag", 32'(gameOver), 1);
        idleCycle();
        checkOutput("lifeLost drop", 32'(lifeLostPulse), 0);
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 1'b0);
        checkOutput("restart lives", 32'(livesLeft), 3);
        checkOutput("restart level", 32'(level), 0);

        // Win by clearing every level.
        for (int l = 0; l < LEVELS; l++) clearLevel();
        checkOutput("win state", 32'(state), 8);
        checkOutput("win level", 32'(level), 3);
        checkOutput("win flag", 32'(win), 1);
        checkOutput("win freeze", 32'(freezeMonkey), 1);

        // Reset during DYING.
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b001, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 2'b00, 1'b1);
        checkOutput("dying before reset", 32'(state), 5);
        @(negedge clk);
        waterCollision = 1'b0;
        resetN = 1'b0;
        #1;
        checkOutput("async reset state", 32'(state), 0);
        checkOutput("async reset lives", 32'(livesLeft), 3);
        checkOutput("async reset respawnN", 32'(respawnN), 1);
        @(negedge clk);
        resetN = 1'b1;

        // Randomized play against the model.
        for (int c = 0; c < 5000; c++) begin
            logic [NUMBERS-1:0] nh;
            logic [1:0]         op;
            if ($urandom_range(0, 15) == 0) targetValue = VALUE_W'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0)
                numberValues = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
            if ($urandom_range(0, 999) == 0) begin
                @(negedge clk);
                resetN = 1'b0;
                @(negedge clk);
                resetN = 1'b1;
            end
            for (int b = 0; b < NUMBERS; b++) nh[b] = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 2; b++) op[b] = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, nh, op,
                          $urandom_range(0, 49) == 0);
        end
        idleCycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
